// File: rtl/wave_sequencer.sv
// wave_sequencer: replays per-level enemy-spawn scripts at a fixed tick rate and drives scene flags.
// Define PAUSE_EN to build the optional PAUSE state (toggled by key 8'h13).
module wave_sequencer #(
    parameter int         TICK_CYCLES  = 50000000,
    parameter int         NUM_LEVELS   = 4,
    parameter int         SCRIPT_DEPTH = 64,
    parameter int         SUMMON_W     = 3,
    parameter int         ROUND_W      = 3,
    parameter logic [7:0] KEY_NEXT     = 8'h2C,
    parameter logic [7:0] KEY_RETRY    = 8'h50,
    localparam int        LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int        SW = (SCRIPT_DEPTH > 1) ? $clog2(SCRIPT_DEPTH) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic                death,
    input  logic [7:0]          keycode,
    input  logic                wr_en,
    input  logic [LW-1:0]       wr_level,
    input  logic [SW-1:0]       wr_addr,
    input  logic [7:0]          wr_data,
    output logic                wr_ready,
    output logic [SUMMON_W-1:0] summon,
    output logic                summon_valid,
    output logic                is_open,
    output logic                is_game,
    output logic                is_vict,
    output logic                is_fail,
    output logic [LW-1:0]       level_index,
    output logic [ROUND_W-1:0]  round,
    output logic [SW-1:0]       step,
    output logic [7:0]          command
);

    localparam int            CW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(SCRIPT_DEPTH - 1);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(NUM_LEVELS - 1);
    localparam logic [7:0]    CMD_ROUND  = 8'h09;
    localparam logic [7:0]    CMD_VICT   = 8'h0A;

    typedef enum logic [2:0] {
        S_OPEN,
        S_PLAY,
        S_VICT,
        S_FAIL
`ifdef PAUSE_EN
        , S_PAUSE
`endif
    } state_t;

    typedef struct packed {
        logic          en;
        logic [LW-1:0] level;
        logic [SW-1:0] addr;
        logic [7:0]    data;
    } wr_req_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [LW-1:0] level_nxt;
    logic          enter_play;
    logic          tick_exec;
    logic          tick;
    logic          cnt_run;
    logic          is_summon;
    logic          pause_press;
    wr_req_t       wr_req;

    logic [7:0] script_mem [NUM_LEVELS][SCRIPT_DEPTH];

    // Script memory survives Reset so a loaded campaign can be replayed.
    assign wr_req = '{en: wr_en & wr_ready, level: wr_level, addr: wr_addr, data: wr_data};

    always_ff @(posedge Clk) begin
        if (wr_req.en && (int'(wr_req.level) < NUM_LEVELS))
            script_mem[wr_req.level][wr_req.addr] <= wr_req.data;
    end

    assign command   = script_mem[level_index][step];
    assign is_summon = (command >= 8'h01) && (command <= 8'h07);
    assign tick      = (cnt == TICK_LAST);

`ifdef PAUSE_EN
    // Edge-detected so a held key toggles only once.
    logic pause_key_d;
    always_ff @(posedge Clk) begin
        if (Reset) pause_key_d <= 1'b0;
        else       pause_key_d <= (keycode == 8'h13);
    end
    assign pause_press = (keycode == 8'h13) && !pause_key_d;
`else
    assign pause_press = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_OPEN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        level_nxt  = level_index;
        enter_play = 1'b0;
        tick_exec  = 1'b0;
        case (state)
            S_OPEN: if (Run) begin
                state_nxt  = S_PLAY;
                enter_play = 1'b1;
                level_nxt  = '0;
            end
            S_PLAY: begin
                if (death) begin
                    state_nxt = S_FAIL;
                end else if (pause_press) begin
`ifdef PAUSE_EN
                    state_nxt = S_PAUSE;
`endif
                end else if (tick) begin
                    tick_exec = 1'b1;
                    if (command == CMD_VICT || step == STEP_LAST) state_nxt = S_VICT;
                end
            end
            S_VICT: begin
                if (keycode == KEY_RETRY) begin
                    state_nxt  = S_PLAY;
                    enter_play = 1'b1;
                end else if (keycode == KEY_NEXT) begin
                    if (level_index == LEVEL_LAST) begin
                        state_nxt = S_OPEN;
                        level_nxt = '0;
                    end else begin
                        state_nxt  = S_PLAY;
                        enter_play = 1'b1;
                        level_nxt  = level_index + 1'b1;
                    end
                end
            end
            S_FAIL: if (keycode == KEY_NEXT) begin
                state_nxt = S_OPEN;
                level_nxt = '0;
            end
`ifdef PAUSE_EN
            S_PAUSE: begin
                if (death)            state_nxt = S_FAIL;
                else if (pause_press) state_nxt = S_PLAY;
            end
`endif
            default: state_nxt = S_OPEN;
        endcase
    end

    // Counter freezes on the cycle PLAY is left so a resume continues where it stopped.
    assign cnt_run = (state == S_PLAY) && !death && !pause_press;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt          <= '0;
            step         <= '0;
            round        <= '0;
            level_index  <= '0;
            summon       <= '0;
            summon_valid <= 1'b0;
        end else begin
            level_index  <= level_nxt;
            summon_valid <= 1'b0;
            if (enter_play) begin
                cnt   <= '0;
                step  <= '0;
                round <= '0;
            end else begin
                if (cnt_run) cnt <= tick ? '0 : cnt + 1'b1;
                if (tick_exec) begin
                    if (step != STEP_LAST) step <= step + 1'b1;
                    if (command == CMD_ROUND && round != '1) round <= round + 1'b1;
                    if (is_summon) begin
                        summon       <= command[SUMMON_W-1:0];
                        summon_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign wr_ready = (state == S_OPEN) || (state == S_VICT) || (state == S_FAIL);
    assign is_open  = (state == S_OPEN);
    assign is_vict  = (state == S_VICT);
    assign is_fail  = (state == S_FAIL);
`ifdef PAUSE_EN
    assign is_game  = (state == S_PLAY) || (state == S_PAUSE);
`else
    assign is_game  = (state == S_PLAY);
`endif

endmodule
